// File: rtl/romix_seq_ctrl_if.sv
// Handshake bundle between the ROMix sequencer, its scratchpad and the BlockMix core.
// master = sequencer side, slave = memory/BlockMix/host side.
interface romix_seq_ctrl_if #(parameter int N_LOG2 = 10) ();
  logic                start;
  logic                mem_ready;
  logic                bm_done;
  logic [N_LOG2-1:0]   j_in;
  logic                mem_we;
  logic                mem_re;
  logic [N_LOG2+4:0]   mem_addr;
  logic                bm_start;
  logic                phase;
  logic                busy;
  logic                done;

  modport master (
    input  start, mem_ready, bm_done, j_in,
    output mem_we, mem_re, mem_addr, bm_start, phase, busy, done
  );

  modport slave (
    output start, mem_ready, bm_done, j_in,
    input  mem_we, mem_re, mem_addr, bm_start, phase, busy, done
  );
endinterface

// File: rtl/romix_seq_ctrl.sv
// ROMix sequencer: fills N scratchpad blocks, then reads N data-dependent blocks,
// launching BlockMix after every 32-word block transfer.
//
// state   | meaning
// IDLE    | waiting for start
// WR_XFER | writing block it, word wd, to the scratchpad
// WR_MIX  | BlockMix running on the block just written
// RD_XFER | reading block jl, word wd, from the scratchpad
// RD_MIX  | BlockMix running on the block just read
// DONE    | one-cycle completion pulse
module romix_seq_ctrl #(
  parameter int N_LOG2 = 10
) (
  input  logic             clk,
  input  logic             reset,
  romix_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_XFER = 3'd1,
    WR_MIX  = 3'd2,
    RD_XFER = 3'd3,
    RD_MIX  = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [N_LOG2-1:0] IT_LAST = '1;

  state_t            state, state_nxt;
  logic [4:0]        wd, wd_nxt;
  logic [N_LOG2-1:0] it, it_nxt;
  logic [N_LOG2-1:0] jl, jl_nxt;
  // High only in the first cycle of a MIX visit; doubles as bm_start and masks bm_done.
  logic              mix_first, mix_first_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wd        <= '0;
      it        <= '0;
      jl        <= '0;
      mix_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      wd        <= wd_nxt;
      it        <= it_nxt;
      jl        <= jl_nxt;
      mix_first <= mix_first_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wd_nxt        = wd;
    it_nxt        = it;
    jl_nxt        = jl;
    mix_first_nxt = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    bus.done      = 1'b0;
    bus.bm_start  = mix_first;
    bus.busy      = (state != IDLE);
    bus.phase     = (state == RD_XFER) || (state == RD_MIX) || (state == DONE);

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = WR_XFER;
          wd_nxt    = '0;
          it_nxt    = '0;
        end
      end
      WR_XFER: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = {it, wd};
        if (bus.mem_ready) begin
          wd_nxt = wd + 5'd1;
          if (wd == 5'd31) begin
            state_nxt     = WR_MIX;
            mix_first_nxt = 1'b1;
          end
        end
      end
      WR_MIX: begin
        if (!mix_first && bus.bm_done) begin
          if (it == IT_LAST) begin
            state_nxt = RD_XFER;
            it_nxt    = '0;
            jl_nxt    = bus.j_in;
          end else begin
            state_nxt = WR_XFER;
            it_nxt    = it + 1'b1;
          end
        end
      end
      RD_XFER: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {jl, wd};
        if (bus.mem_ready) begin
          wd_nxt = wd + 5'd1;
          if (wd == 5'd31) begin
            state_nxt     = RD_MIX;
            mix_first_nxt = 1'b1;
          end
        end
      end
      RD_MIX: begin
        if (!mix_first && bus.bm_done) begin
          if (it == IT_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RD_XFER;
            it_nxt    = it + 1'b1;
            jl_nxt    = bus.j_in;
          end
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_romix_seq_ctrl.sv
// Directed bench for romix_seq_ctrl at N_LOG2=2: scoreboarded scratchpad accesses
// plus timing, stall, ignored-start, early-bm_done and mid-run reset scenarios.
module tb_romix_seq_ctrl;
  logic clk = 1'b0;
  logic reset;

  romix_seq_ctrl_if #(.N_LOG2(2)) bus ();

  romix_seq_ctrl #(.N_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int jtab [8]  = '{2, 1, 0, 3, 0, 2, 1, 3};
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full run; caller is #1 after a rising edge with the DUT idle.
  task automatic run(input string name, input int stall_blk, input bit early,
                     input bit poke, input int exp_done);
    int   done_at   = -1;
    int   done_cnt  = 0;
    int   busy_cnt  = 0;
    int   bms_cnt   = 0;
    int   jidx      = 0;
    int   stall_cnt = 0;
    bit   prev_bms  = 0;
    bit   prev_bms2 = 0;
    bit   poked_rd  = 0;
    bit   real_done;
    logic [15:0] e;
    exp_q.delete();
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 32; w++) begin
        e = {7'd0, 1'b1, 1'b0, 7'(b * 32 + w)};
        exp_q.push_back(e);
      end
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 32; w++) begin
        e = {7'd0, 1'b0, 1'b1, 7'(jtab[3 + k] * 32 + w)};
        exp_q.push_back(e);
      end

    bus.start = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 4; cyc++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.mem_ready = 1'b1;
      bus.bm_done   = 1'b0;
      if (cyc == 1)
        chk({name, "_latency"}, {7'd0, bus.mem_we, bus.phase, bus.mem_addr}, 16'h0100);
      if (bus.mem_we && bus.mem_addr[4:0] == 5'd31 && int'(bus.mem_addr[6:5]) == stall_blk
          && stall_cnt < 5) begin
        bus.mem_ready = 1'b0;
        stall_cnt++;
        chk({name, "_stall_bmstart"}, {15'd0, bus.bm_start}, 16'd0);
      end
      real_done = early ? prev_bms2 : prev_bms;
      if (real_done || (early && bus.bm_start)) bus.bm_done = 1'b1;
      bus.j_in = 2'(jtab[jidx % 8]);
      if (real_done) jidx++;
      if (poke && bus.mem_re && !poked_rd) begin
        bus.start = 1'b1;
        poked_rd  = 1'b1;
      end
      if (poke && bus.done) bus.start = 1'b1;

      if ((bus.mem_we || bus.mem_re) && bus.mem_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({name, "_access"}, {7'd0, bus.mem_we, bus.mem_re, bus.mem_addr}, e);
          chk({name, "_phase"}, {15'd0, bus.phase}, {15'd0, bus.mem_re});
        end else begin
          chk({name, "_extra_access"}, {7'd0, bus.mem_we, bus.mem_re, bus.mem_addr}, 16'd0);
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.bm_start) bms_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = cyc;
      end
      prev_bms2 = prev_bms;
      prev_bms  = bus.bm_start;
    end
    bus.start = 1'b0;
    bus.bm_done = 1'b0;
    chk({name, "_done_cycle"}, 16'(done_at), 16'(exp_done));
    chk({name, "_done_count"}, 16'(done_cnt), 16'd1);
    chk({name, "_busy_cycles"}, 16'(busy_cnt), 16'(exp_done));
    chk({name, "_bm_start_count"}, 16'(bms_cnt), 16'd8);
    chk({name, "_accesses_left"}, 16'(exp_q.size()), 16'd0);
    chk({name, "_idle_after"}, {15'd0, bus.busy}, 16'd0);
  endtask

  initial begin
    bit found = 0;
    bit prev  = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.bm_done   = 1'b0;
    bus.j_in      = '0;
    #12;
    chk("reset_outputs", {7'd0, bus.mem_we, bus.mem_re, bus.mem_addr} |
        {12'd0, bus.bm_start, bus.phase, bus.busy, bus.done}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run("basic", -1, 1'b0, 1'b0, 273);
    run("stall", 1, 1'b0, 1'b0, 278);
    run("ignored_start", -1, 1'b0, 1'b1, 273);
    run("early_done", -1, 1'b1, 1'b0, 281);

    // Reset abandoned in the first RD_MIX cycle.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.phase && bus.bm_start) begin
        found = 1;
        break;
      end
      bus.mem_ready = 1'b1;
      bus.bm_done   = prev;
      prev          = bus.bm_start;
      @(posedge clk); #1;
    end
    chk("reach_rd_mix", {15'd0, found}, 16'd1);
    bus.bm_done = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrun_reset_outputs", {7'd0, bus.mem_we, bus.mem_re, bus.mem_addr} |
        {12'd0, bus.bm_start, bus.phase, bus.busy, bus.done}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("no_done_after_reset", {14'd0, bus.done, bus.busy}, 16'd0);
    run("after_reset", -1, 1'b0, 1'b0, 273);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
